// File: rtl/ysyx_22050133_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22050133_div_arbiter
// Purpose : two-port round-robin front end for one shared iterative divider
//           (optional divide-by-zero bypass: DIV_ZERO_BYPASS_EN)
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22050133_div_arbiter #(
  parameter int XLEN     = 64,
  parameter int WAIT_MAX = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [1:0]          i_req_divw,
  input  logic [1:0]          i_req_signed,
  input  logic [2*XLEN-1:0]   i_req_dividend,
  input  logic [2*XLEN-1:0]   i_req_divisor,
  input  logic [1:0]          i_req_flush,
  output logic [1:0]          o_resp_valid,
  output logic [XLEN-1:0]     o_resp_quotient,
  output logic [XLEN-1:0]     o_resp_remainder,
  output logic                o_busy,
  output logic                o_wdog_err,
  output logic                o_div_valid,
  output logic                o_div_divw,
  output logic                o_div_signed,
  output logic [XLEN-1:0]     o_div_dividend,
  output logic [XLEN-1:0]     o_div_divisor,
  output logic                o_div_flush,
  input  logic                i_div_ready,
  input  logic                i_div_out_valid,
  input  logic [XLEN-1:0]     i_div_quotient,
  input  logic [XLEN-1:0]     i_div_remainder
);

  localparam int c_CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_owner;
  logic                 r_last_grant;
  logic                 r_divw;
  logic                 r_signed;
  logic [XLEN-1:0]      r_dividend;
  logic [XLEN-1:0]      r_divisor;
  logic [XLEN-1:0]      r_resp_q;
  logic [XLEN-1:0]      r_resp_r;
  logic [1:0]           r_req_ready;
  logic                 r_wdog_err;
  logic [c_CNT_W-1:0]   r_wcnt;

  logic [1:0]           w_eff;
  logic                 w_grant;
  logic                 w_gnt_divw;
  logic                 w_gnt_signed;
  logic [XLEN-1:0]      w_gnt_dividend;
  logic [XLEN-1:0]      w_gnt_divisor;
  logic                 w_zero_div;
  logic [XLEN-1:0]      w_zero_rem;
  logic                 w_owner_flush;
  logic                 w_wdog_hit;
  logic                 w_div_flush;

  assign w_eff          = i_req_valid & ~i_req_flush;
  // On contention the port that did not win last time goes first.
  assign w_grant        = (&w_eff) ? ~r_last_grant : w_eff[1];
  assign w_gnt_divw     = i_req_divw[w_grant];
  assign w_gnt_signed   = i_req_signed[w_grant];
  assign w_gnt_dividend = w_grant ? i_req_dividend[XLEN +: XLEN] : i_req_dividend[0 +: XLEN];
  assign w_gnt_divisor  = w_grant ? i_req_divisor[XLEN +: XLEN]  : i_req_divisor[0 +: XLEN];

`ifdef DIV_ZERO_BYPASS_EN
  assign w_zero_div = w_gnt_divw ? (w_gnt_divisor[31:0] == 32'd0) : (w_gnt_divisor == '0);
  assign w_zero_rem = w_gnt_divw ?
      {{(XLEN-32){w_gnt_signed & w_gnt_dividend[31]}}, w_gnt_dividend[31:0]} : w_gnt_dividend;
`else
  assign w_zero_div = 1'b0;
  assign w_zero_rem = w_gnt_dividend;
`endif

  assign w_owner_flush = i_req_flush[r_owner];
  // Counter starts at 0 on WAIT entry, so WAIT_MAX-1 marks the last allowed cycle.
  assign w_wdog_hit    = (r_wcnt == c_CNT_W'(WAIT_MAX - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_div_flush = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_eff) w_state_nxt = w_zero_div ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (w_owner_flush) begin
          w_div_flush = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (i_div_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_owner_flush) begin
          w_div_flush = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (i_div_out_valid) begin
          w_state_nxt = S_RESP;
        end else if (w_wdog_hit) begin
          w_div_flush = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_divw       <= 1'b0;
      r_signed     <= 1'b0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_resp_q     <= '0;
      r_resp_r     <= '0;
      r_req_ready  <= 2'b00;
      r_wdog_err   <= 1'b0;
      r_wcnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= 2'b00;
      r_wdog_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_eff) begin
            r_req_ready  <= w_grant ? 2'b10 : 2'b01;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_divw       <= w_gnt_divw;
            r_signed     <= w_gnt_signed;
            r_dividend   <= w_gnt_dividend;
            r_divisor    <= w_gnt_divisor;
            if (w_zero_div) begin
              r_resp_q <= '1;
              r_resp_r <= w_zero_rem;
            end
          end
        end
        S_ISSUE: r_wcnt <= '0;
        S_WAIT: begin
          r_wcnt <= r_wcnt + 1'b1;
          if (!w_owner_flush) begin
            if (i_div_out_valid) begin
              r_resp_q <= i_div_quotient;
              r_resp_r <= i_div_remainder;
            end else if (w_wdog_hit) begin
              r_resp_q   <= '1;
              r_resp_r   <= '0;
              r_wdog_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready      = r_req_ready;
  assign o_resp_valid     = (r_state == S_RESP && !w_owner_flush) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign o_resp_quotient  = r_resp_q;
  assign o_resp_remainder = r_resp_r;
  assign o_busy           = (r_state != S_IDLE);
  assign o_wdog_err       = r_wdog_err;
  assign o_div_valid      = (r_state == S_ISSUE) && !w_owner_flush;
  assign o_div_divw       = r_divw;
  assign o_div_signed     = r_signed;
  assign o_div_dividend   = r_dividend;
  assign o_div_divisor    = r_divisor;
  assign o_div_flush      = w_div_flush;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050133_div_arbiter.sv
`default_nettype none
// Scoreboard bench for ysyx_22050133_div_arbiter with a behavioural divider model.
module tb_ysyx_22050133_div_arbiter;

  localparam int XLEN = 64;
  localparam int WMAX = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0]       req_divw = '0;
  logic [1:0]       req_signed = '0;
  logic [127:0]     req_dividend = '0;
  logic [127:0]     req_divisor = '0;
  logic [1:0]       req_flush = '0;
  logic [1:0]       resp_valid;
  logic [63:0]      resp_q;
  logic [63:0]      resp_r;
  logic             busy;
  logic             wdog_err;
  logic             div_valid;
  logic             div_divw;
  logic             div_signed;
  logic [63:0]      div_dividend;
  logic [63:0]      div_divisor;
  logic             div_flush;
  logic             div_ready = 1'b1;
  logic             div_out_valid;
  logic [63:0]      div_q;
  logic [63:0]      div_r;

  always #5 clk = ~clk;

  ysyx_22050133_div_arbiter #(.XLEN(XLEN), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_divw(req_divw), .i_req_signed(req_signed),
    .i_req_dividend(req_dividend), .i_req_divisor(req_divisor),
    .i_req_flush(req_flush),
    .o_resp_valid(resp_valid), .o_resp_quotient(resp_q), .o_resp_remainder(resp_r),
    .o_busy(busy), .o_wdog_err(wdog_err),
    .o_div_valid(div_valid), .o_div_divw(div_divw), .o_div_signed(div_signed),
    .o_div_dividend(div_dividend), .o_div_divisor(div_divisor), .o_div_flush(div_flush),
    .i_div_ready(div_ready), .i_div_out_valid(div_out_valid),
    .i_div_quotient(div_q), .i_div_remainder(div_r)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- divider model ----------------
  int          model_lat = 5;
  logic        model_hang = 1'b0;
  int          m_cnt;
  logic        m_pend;
  logic [63:0] m_q, m_r;
  int          dv_cnt = 0;
  int          cyc = 0;

  function automatic void ref_div(input logic w, input logic s, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin q32 = '1; r32 = a32; end
      else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin q = '1; r = a; end
      else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_cnt <= 0;
      div_out_valid <= 1'b0;
      div_q <= '0;
      div_r <= '0;
    end else begin
      div_out_valid <= 1'b0;
      if (div_flush) begin
        m_pend <= 1'b0;
      end else if (div_valid && div_ready) begin
        logic [63:0] q, r;
        ref_div(div_divw, div_signed, div_dividend, div_divisor, q, r);
        m_q <= q;
        m_r <= r;
        m_pend <= 1'b1;
        m_cnt <= model_lat;
      end else if (m_pend) begin
        if (m_cnt <= 1) begin
          m_pend <= 1'b0;
          if (!model_hang) begin
            div_out_valid <= 1'b1;
            div_q <= m_q;
            div_r <= m_r;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_valid && div_ready) dv_cnt <= dv_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        wd;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   resp_cnt[2] = '{0, 0};
  int   resp_cyc[2] = '{0, 0};
  int   grants[$];
  logic log_grants = 1'b0;
  logic [1:0] prev_rdy = 2'b00;

  task automatic push(input int p, input logic [63:0] q, input logic [63:0] r, input logic wd);
    exp_t e;
    e.q = q; e.r = r; e.wd = wd;
    if (p == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic empty;
    forever begin
      @(negedge clk);
      #2;
      if (resp_valid == 2'b11) chk("resp_valid onehot", 64'(resp_valid), 64'd1);
      for (int p = 0; p < 2; p++) begin
        if (req_ready[p]) begin
          chk("req_ready pulse", 64'(prev_rdy[p]), 64'd0);
          if (log_grants) grants.push_back(p);
        end
        if (resp_valid[p]) begin
          resp_cnt[p]++;
          resp_cyc[p] = cyc;
          empty = (p == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
          if (empty) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected resp port %0d: got q=%h r=%h required none", p, resp_q, resp_r);
          end else begin
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("resp_q port%0d", p), resp_q, e.q);
            chk($sformatf("resp_r port%0d", p), resp_r, e.r);
            chk($sformatf("wdog_err port%0d", p), 64'(wdog_err), 64'(e.wd));
          end
        end
      end
      prev_rdy = req_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int p, input logic w, input logic s, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_divw[p] = w;
    req_signed[p] = s;
    req_dividend[p*64 +: 64] = a;
    req_divisor[p*64 +: 64] = b;
    req_valid[p] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        req_valid[p] = 1'b0;
        return;
      end
    end
    req_valid[p] = 1'b0;
    n_chk++; n_fail++;
    $display("FAIL accept timeout port %0d: got no req_ready required a pulse", p);
  endtask

  task automatic wait_qlen(input int p, input int len);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #3;
      if (((p == 0) ? exp_q0.size() : exp_q1.size()) <= len) return;
    end
    n_chk++; n_fail++;
    $display("FAIL response timeout port %0d: got none required one", p);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #3;
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && !busy) return;
    end
    n_chk++; n_fail++;
    $display("FAIL drain timeout: got %0d/%0d pending required 0/0", exp_q0.size(), exp_q1.size());
  endtask

  task automatic wait_handshake();
    for (int i = 0; i < 100; i++) begin
      #1;
      if (div_valid && div_ready) return;
      @(negedge clk);
    end
    n_chk++; n_fail++;
    $display("FAIL handshake timeout: got no div_valid required one");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout: got no end required end of test");
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    int base, n, flush_n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset div_valid", 64'(div_valid), 64'd0);
    chk("reset div_flush", 64'(div_flush), 64'd0);
    chk("reset wdog_err", 64'(wdog_err), 64'd0);
    chk("reset resp_q", resp_q, 64'd0);
    chk("reset resp_r", resp_r, 64'd0);

    // unsigned 100/7 on port 0
    push(0, 64'd14, 64'd2, 1'b0);
    send(0, 1'b0, 1'b0, 64'd100, 64'd7);
    wait_qlen(0, 0);
    @(negedge clk);
    #1;
    chk("busy after resp", 64'(busy), 64'd0);

    // contention after reset: port 0 must win
    do_reset();
    push(0, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    push(1, 64'd4, 64'd1, 1'b0);
    fork
      send(0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
      send(1, 1'b1, 1'b0, 64'd9, 64'd2);
    join
    wait_drain();
    chk("port0 served first", 64'(resp_cyc[0] < resp_cyc[1]), 64'd1);

    // alternating grants with both ports kept busy
    grants.delete();
    log_grants = 1'b1;
    push(0, 64'd10, 64'd0, 1'b0);
    push(0, 64'd6, 64'd3, 1'b0);
    push(1, 64'd5, 64'd2, 1'b0);
    push(1, 64'd9, 64'd0, 1'b0);
    fork
      begin
        send(0, 1'b0, 1'b0, 64'd40, 64'd4);
        wait_qlen(0, 1);
        send(0, 1'b0, 1'b0, 64'd33, 64'd5);
      end
      begin
        send(1, 1'b0, 1'b0, 64'd17, 64'd3);
        wait_qlen(1, 1);
        send(1, 1'b0, 1'b0, 64'd81, 64'd9);
      end
    join
    wait_drain();
    log_grants = 1'b0;
    chk("grant count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk($sformatf("grant order %0d", i), 64'(grants[i]), 64'(i % 2));

    // owner flush 10 cycles into WAIT
    model_lat = 15;
    base = resp_cnt[1];
    send(1, 1'b0, 1'b0, 64'd1000, 64'd10);
    wait_handshake();
    repeat (10) @(negedge clk);
    req_flush[1] = 1'b1;
    #1;
    chk("flush div_flush", 64'(div_flush), 64'd1);
    chk("flush busy in WAIT", 64'(busy), 64'd1);
    @(negedge clk);
    req_flush[1] = 1'b0;
    #1;
    chk("flush back to idle", 64'(busy), 64'd0);
    chk("flush pulse width", 64'(div_flush), 64'd0);
    push(0, 64'd10, 64'd0, 1'b0);
    send(0, 1'b0, 1'b0, 64'd50, 64'd5);
    wait_drain();
    chk("flushed port silent", 64'(resp_cnt[1] - base), 64'd0);

    // div_ready low for 3 ISSUE cycles
    model_lat = 5;
    div_ready = 1'b0;
    push(0, 64'd11, 64'd0, 1'b0);
    send(0, 1'b0, 1'b0, 64'd77, 64'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("issue hold div_valid", 64'(div_valid), 64'd1);
      chk("issue hold dividend", div_dividend, 64'd77);
      chk("issue hold divisor", div_divisor, 64'd7);
      @(negedge clk);
    end
    div_ready = 1'b1;
    #1;
    chk("issue 4th div_valid", 64'(div_valid), 64'd1);
    @(negedge clk);
    #1;
    chk("wait div_valid low", 64'(div_valid), 64'd0);
    wait_drain();

    // watchdog with a hung divider
    model_hang = 1'b1;
    push(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    send(1, 1'b0, 1'b0, 64'd5, 64'd1);
    wait_handshake();
    n = 0;
    flush_n = -1;
    while (!wdog_err && n < 100) begin
      @(negedge clk);
      #1;
      n++;
      if (div_flush) flush_n = n;
    end
    chk("wdog_err timing", 64'(n), 64'd21);
    chk("wdog div_flush timing", 64'(flush_n), 64'd20);
    wait_drain();
    model_hang = 1'b0;

    // divide by zero, signed divw
    base = dv_cnt;
    push(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0);
    wait_drain();
`ifdef DIV_ZERO_BYPASS_EN
    chk("div0 divider starts", 64'(dv_cnt - base), 64'd0);
`else
    chk("div0 divider starts", 64'(dv_cnt - base), 64'd1);
`endif

    // reset mid-operation discards the transaction
    model_lat = 15;
    base = resp_cnt[0];
    send(0, 1'b0, 1'b0, 64'd9, 64'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop reset busy", 64'(busy), 64'd0);
    chk("midop reset div_valid", 64'(div_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #3;
    chk("midop reset no resp", 64'(resp_cnt[0] - base), 64'd0);
    chk("scoreboard port0 empty", 64'(exp_q0.size()), 64'd0);
    chk("scoreboard port1 empty", 64'(exp_q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
